// File: rtl/reshape_sched.sv
// reshape_sched -- run sequencer for one matrix-multiply job.
//
// On a host start it latches the matrix dimensions, fires both reshape units,
// waits for both reshapers to report finish, fires the systolic array, waits
// for its finish, then reports done. A zero dimension aborts the run, and so
// does the optional per-phase watchdog.
//
// Optional feature: define RESHAPE_SCHED_TIMEOUT_EN to build the watchdog.
// Without it the wait states wait indefinitely and err_code 2'b10 never occurs.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, level-sampled in IDLE
//   M, N, P             dimensions (input M x P, weight P x N)
//   reshape_start       one-cycle pulse to both reshape units
//   IM/WM_reshape_finish  reshaper finish levels (sticky-high)
//   compute_start       one-cycle pulse to the systolic array
//   compute_finish      array finish level (sticky-high)
//   M_o, N_o, P_o       dimensions latched for the run
//   busy, done, err     status; done/err stay high until the next accepted start
//   err_code            01 = zero dimension, 10 = timeout
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | dimensions latched, checked for zero
// RSH_GO   | reshape_start pulse, finish flags cleared
// RSH_WAIT | waiting for a fresh rise on both reshaper finishes
// CMP_GO   | compute_start pulse
// CMP_WAIT | waiting for a fresh rise on compute_finish
// FIN      | done raised, back to IDLE next cycle
// ERR      | err raised, back to IDLE next cycle
module reshape_sched #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] M,
  input  logic [15:0] N,
  input  logic [15:0] P,
  output logic        reshape_start,
  input  logic        IM_reshape_finish,
  input  logic        WM_reshape_finish,
  output logic        compute_start,
  input  logic        compute_finish,
  output logic [15:0] M_o,
  output logic [15:0] N_o,
  output logic [15:0] P_o,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RSH_GO, RSH_WAIT, CMP_GO, CMP_WAIT, FIN, ERR
  } state_t;

  state_t state;

  // Finish inputs are levels that stay high across runs, so only a 0->1
  // transition against the previous cycle's copy counts as a new finish.
  logic im_q, wm_q, cf_q;
  logic im_seen, wm_seen;
  logic im_rise, wm_rise, cf_rise;

  assign im_rise = IM_reshape_finish & ~im_q;
  assign wm_rise = WM_reshape_finish & ~wm_q;
  assign cf_rise = compute_finish & ~cf_q;

`ifdef RESHAPE_SCHED_TIMEOUT_EN
  // Counter holds the number of completed cycles in the wait state; the
  // compare against limit-1 trips on the cycle the count reaches the limit.
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      im_q          <= 1'b0;
      wm_q          <= 1'b0;
      cf_q          <= 1'b0;
      im_seen       <= 1'b0;
      wm_seen       <= 1'b0;
      reshape_start <= 1'b0;
      compute_start <= 1'b0;
      M_o           <= '0;
      N_o           <= '0;
      P_o           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'b00;
`ifdef RESHAPE_SCHED_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      im_q          <= IM_reshape_finish;
      wm_q          <= WM_reshape_finish;
      cf_q          <= compute_finish;
      reshape_start <= 1'b0;
      compute_start <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            M_o      <= M;
            N_o      <= N;
            P_o      <= P;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
          end
        end

        LOAD: begin
          if ((M_o == 16'd0) || (N_o == 16'd0) || (P_o == 16'd0)) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'b01;
          end else begin
            state         <= RSH_GO;
            reshape_start <= 1'b1;
          end
        end

        RSH_GO: begin
          state   <= RSH_WAIT;
          im_seen <= 1'b0;
          wm_seen <= 1'b0;
`ifdef RESHAPE_SCHED_TIMEOUT_EN
          wd_cnt  <= '0;
`endif
        end

        RSH_WAIT: begin
          if (im_rise) im_seen <= 1'b1;
          if (wm_rise) wm_seen <= 1'b1;
          if (im_seen && wm_seen) begin
            state         <= CMP_GO;
            compute_start <= 1'b1;
          end
`ifdef RESHAPE_SCHED_TIMEOUT_EN
          else if (wd_cnt == TO_LIMIT) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end

        CMP_GO: begin
          state  <= CMP_WAIT;
`ifdef RESHAPE_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        CMP_WAIT: begin
          if (cf_rise) begin
            state <= FIN;
            done  <= 1'b1;
          end
`ifdef RESHAPE_SCHED_TIMEOUT_EN
          else if (wd_cnt == TO_LIMIT) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end

        FIN, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reshape_sched.sv
// tb_reshape_sched -- directed self-checking bench for reshape_sched.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Build with RESHAPE_SCHED_TIMEOUT_EN defined to exercise the watchdog
// (TIMEOUT_CYCLES = 16); otherwise the bench checks the wait is indefinite.
module tb_reshape_sched;

`ifdef RESHAPE_SCHED_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] M = '0, N = '0, P = '0;
  logic        reshape_start;
  logic        IM_reshape_finish = 1'b0;
  logic        WM_reshape_finish = 1'b0;
  logic        compute_start;
  logic        compute_finish = 1'b0;
  logic [15:0] M_o, N_o, P_o;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int rs_cnt = 0;
  int cs_cnt = 0;
  int rs0, cs0;

  reshape_sched #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .M(M), .N(N), .P(P),
    .reshape_start(reshape_start),
    .IM_reshape_finish(IM_reshape_finish),
    .WM_reshape_finish(WM_reshape_finish),
    .compute_start(compute_start),
    .compute_finish(compute_finish),
    .M_o(M_o), .N_o(N_o), .P_o(P_o),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Pulse counters: each count is one clock cycle the pulse was high.
  always @(negedge clk) begin
    if (reshape_start === 1'b1) rs_cnt++;
    if (compute_start === 1'b1) cs_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, done, err, err_code, reshape_start, compute_start} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b exp 0", {busy, done, err, err_code, reshape_start, compute_start});
    end
    n_cmp++;
    if ({M_o, N_o, P_o} !== 48'd0) begin
      n_bad++; $display("FAIL reset_dims got %h exp 0", {M_o, N_o, P_o});
    end
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_nominal();
    rs0 = rs_cnt; cs0 = cs_cnt;
    M = 16'd4; N = 16'd8; P = 16'd5; start = 1'b1;
    cyc(1);                          // LOAD
    start = 1'b0;
    n_cmp++;
    if ({busy, M_o, N_o, P_o} !== {1'b1, 16'd4, 16'd8, 16'd5}) begin
      n_bad++; $display("FAIL nom_latch got busy=%b %0d/%0d/%0d exp 1 4/8/5", busy, M_o, N_o, P_o);
    end
    cyc(1);                          // RSH_GO
    n_cmp++;
    if (reshape_start !== 1'b1) begin
      n_bad++; $display("FAIL nom_rs_pulse got %b exp 1", reshape_start);
    end
    cyc(1);
    n_cmp++;
    if (reshape_start !== 1'b0) begin
      n_bad++; $display("FAIL nom_rs_end got %b exp 0", reshape_start);
    end
    cyc(9);
    WM_reshape_finish = 1'b1;        // 10 cycles after reshape_start
    cyc(10);
    IM_reshape_finish = 1'b1;        // 20 cycles after reshape_start
    cyc(1);                          // IM rise sampled
    n_cmp++;
    if (compute_start !== 1'b0) begin
      n_bad++; $display("FAIL nom_cs_early got %b exp 0", compute_start);
    end
    cyc(1);
    n_cmp++;
    if (compute_start !== 1'b1) begin
      n_bad++; $display("FAIL nom_cs_pulse got %b exp 1", compute_start);
    end
    cyc(30);
    compute_finish = 1'b1;
    cyc(1);                          // FIN
    n_cmp++;
    if ({done, busy} !== 2'b11) begin
      n_bad++; $display("FAIL nom_fin got done,busy=%b exp 11", {done, busy});
    end
    cyc(1);                          // IDLE
    n_cmp++;
    if ({done, busy, err, M_o, N_o, P_o} !== {3'b100, 16'd4, 16'd8, 16'd5}) begin
      n_bad++; $display("FAIL nom_end got done=%b busy=%b err=%b %0d/%0d/%0d exp 1 0 0 4/8/5", done, busy, err, M_o, N_o, P_o);
    end
    n_cmp++;
    if ({rs_cnt - rs0, cs_cnt - cs0} !== {32'd1, 32'd1}) begin
      n_bad++; $display("FAIL nom_pulse_counts got rs=%0d cs=%0d exp 1 1", rs_cnt - rs0, cs_cnt - cs0);
    end
  endtask

  // Reshaper finishes are still high from the nominal run.
  task automatic test_stale_finish();
    int early;
    compute_finish = 1'b0;
    cs0 = cs_cnt;
    M = 16'd2; N = 16'd3; P = 16'd4; start = 1'b1;
    cyc(1);                          // LOAD
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL stale_done_clr got %b exp 0", done);
    end
    cyc(1);                          // RSH_GO
    cyc(1);                          // RSH_WAIT
    IM_reshape_finish = 1'b0;
    WM_reshape_finish = 1'b0;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (compute_start !== 1'b0) early++;
    end
    WM_reshape_finish = 1'b1;
    cyc(3);
    IM_reshape_finish = 1'b1;
    cyc(1);
    if (compute_start !== 1'b0) early++;
    n_cmp++;
    if (early !== 0) begin
      n_bad++; $display("FAIL stale_early_cs got %0d cycles exp 0", early);
    end
    cyc(1);
    n_cmp++;
    if (compute_start !== 1'b1) begin
      n_bad++; $display("FAIL stale_cs_pulse got %b exp 1", compute_start);
    end
    cyc(1);                          // CMP_WAIT
    compute_finish = 1'b1;
    cyc(2);
    n_cmp++;
    if ({done, busy, cs_cnt - cs0} !== {2'b10, 32'd1}) begin
      n_bad++; $display("FAIL stale_end got done=%b busy=%b cs=%0d exp 1 0 1", done, busy, cs_cnt - cs0);
    end
  endtask

  task automatic test_zero_dim();
    IM_reshape_finish = 1'b0; WM_reshape_finish = 1'b0; compute_finish = 1'b0;
    rs0 = rs_cnt;
    M = 16'd3; N = 16'd3; P = 16'd0; start = 1'b1;
    cyc(1);                          // LOAD
    start = 1'b0;
    n_cmp++;
    if ({done, err, busy} !== 3'b001) begin
      n_bad++; $display("FAIL zero_load got done,err,busy=%b exp 001", {done, err, busy});
    end
    cyc(1);                          // ERR
    n_cmp++;
    if ({err, err_code, busy} !== 4'b1011) begin
      n_bad++; $display("FAIL zero_err got err=%b code=%b busy=%b exp 1 01 1", err, err_code, busy);
    end
    cyc(1);                          // IDLE
    n_cmp++;
    if ({err, err_code, busy, rs_cnt - rs0} !== {4'b1010, 32'd0}) begin
      n_bad++; $display("FAIL zero_end got err=%b code=%b busy=%b rs=%0d exp 1 01 0 0", err, err_code, busy, rs_cnt - rs0);
    end
  endtask

  task automatic test_start_held();
    M = 16'd1; N = 16'd0; P = 16'd1; start = 1'b1;
    cyc(3);                          // LOAD, ERR, IDLE
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_bad++; $display("FAIL held_idle got busy,err=%b exp 01", {busy, err});
    end
    cyc(1);                          // relaunched into LOAD
    n_cmp++;
    if ({busy, err} !== 2'b10) begin
      n_bad++; $display("FAIL held_relaunch got busy,err=%b exp 10", {busy, err});
    end
    start = 1'b0;
    cyc(3);
    n_cmp++;
    if ({busy, err, err_code} !== 4'b0101) begin
      n_bad++; $display("FAIL held_end got busy=%b err=%b code=%b exp 0 1 01", busy, err, err_code);
    end
  endtask

  task automatic test_wait_phase();
    IM_reshape_finish = 1'b0; WM_reshape_finish = 1'b0; compute_finish = 1'b0;
    cs0 = cs_cnt;
    M = 16'd1; N = 16'd1; P = 16'd1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);                          // RSH_WAIT entered
    IM_reshape_finish = 1'b1;
`ifdef RESHAPE_SCHED_TIMEOUT_EN
    cyc(15);
    n_cmp++;
    if ({err, busy} !== 2'b01) begin
      n_bad++; $display("FAIL to_before got err,busy=%b exp 01", {err, busy});
    end
    cyc(1);                          // 16th cycle in RSH_WAIT -> ERR
    n_cmp++;
    if ({err, err_code} !== 3'b110) begin
      n_bad++; $display("FAIL to_err got err=%b code=%b exp 1 10", err, err_code);
    end
    cyc(1);
    n_cmp++;
    if ({busy, cs_cnt - cs0} !== {1'b0, 32'd0}) begin
      n_bad++; $display("FAIL to_end got busy=%b cs=%0d exp 0 0", busy, cs_cnt - cs0);
    end
`else
    cyc(100);
    n_cmp++;
    if ({err, busy, cs_cnt - cs0} !== {2'b01, 32'd0}) begin
      n_bad++; $display("FAIL nowd_wait got err=%b busy=%b cs=%0d exp 0 1 0", err, busy, cs_cnt - cs0);
    end
    WM_reshape_finish = 1'b1;
    cyc(2);
    n_cmp++;
    if (compute_start !== 1'b1) begin
      n_bad++; $display("FAIL nowd_cs got %b exp 1", compute_start);
    end
    cyc(1);
    compute_finish = 1'b1;
    cyc(2);
    n_cmp++;
    if ({done, err, busy} !== 3'b100) begin
      n_bad++; $display("FAIL nowd_end got done,err,busy=%b exp 100", {done, err, busy});
    end
`endif
  endtask

  // Leaves the DUT in CMP_WAIT for the mid-run reset test.
  task automatic test_simultaneous();
    IM_reshape_finish = 1'b0; WM_reshape_finish = 1'b0; compute_finish = 1'b0;
    cs0 = cs_cnt;
    M = 16'd9; N = 16'd9; P = 16'd9; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);                          // RSH_WAIT entered
    IM_reshape_finish = 1'b1;
    WM_reshape_finish = 1'b1;
    cyc(1);                          // both flags set
    n_cmp++;
    if (compute_start !== 1'b0) begin
      n_bad++; $display("FAIL sim_early got %b exp 0", compute_start);
    end
    cyc(1);
    n_cmp++;
    if (compute_start !== 1'b1) begin
      n_bad++; $display("FAIL sim_cs got %b exp 1", compute_start);
    end
    cyc(1);
    n_cmp++;
    if ({compute_start, cs_cnt - cs0} !== {1'b0, 32'd1}) begin
      n_bad++; $display("FAIL sim_one_cycle got cs=%b count=%0d exp 0 1", compute_start, cs_cnt - cs0);
    end
  endtask

  task automatic test_midrun_reset();
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, err, err_code, reshape_start, compute_start, M_o, N_o, P_o} !== 55'd0) begin
      n_bad++; $display("FAIL mid_rst got busy=%b done=%b err=%b M_o=%0d exp all 0", busy, done, err, M_o);
    end
    IM_reshape_finish = 1'b0; WM_reshape_finish = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    M = 16'd3; N = 16'd2; P = 16'd7; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    n_cmp++;
    if (reshape_start !== 1'b1) begin
      n_bad++; $display("FAIL mid_rs got %b exp 1", reshape_start);
    end
    cyc(1);
    IM_reshape_finish = 1'b1;
    cyc(2);
    WM_reshape_finish = 1'b1;
    cyc(2);
    n_cmp++;
    if (compute_start !== 1'b1) begin
      n_bad++; $display("FAIL mid_cs got %b exp 1", compute_start);
    end
    cyc(1);
    compute_finish = 1'b1;
    cyc(2);
    n_cmp++;
    if ({done, busy, err, M_o, N_o, P_o} !== {3'b100, 16'd3, 16'd2, 16'd7}) begin
      n_bad++; $display("FAIL mid_end got done=%b busy=%b err=%b %0d/%0d/%0d exp 1 0 0 3/2/7", done, busy, err, M_o, N_o, P_o);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stale_finish();
    test_zero_dim();
    test_start_held();
    test_wait_phase();
    test_simultaneous();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reshape_sched.md
RESHAPE_SCHED -- requirements
Module: reshape_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the per-phase watchdog limit in clock cycles.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  host run request, level-sampled in IDLE.
- M, N, P  in  16 each  matrix dimensions: input is M x P, weight is P x N.
- reshape_start  out  1  one-cycle pulse to both reshape units.
- IM_reshape_finish  in  1  input-matrix reshaper finish, sticky-high.
- WM_reshape_finish  in  1  weight reshaper finish, sticky-high.
- compute_start  out  1  one-cycle pulse to the systolic array.
- compute_finish  in  1  array finish, sticky-high.
- M_o, N_o, P_o  out  16 each  dimensions latched for the run.
- busy  out  1  run in progress.
- done  out  1  run complete, sticky.
- err  out  1  run aborted, sticky.
- err_code  out  2  abort cause: 01 = zero dimension, 10 = timeout.
REQ-003 The clock and reset SHALL be named and behave as stated: one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, RSH_GO, RSH_WAIT, CMP_GO, CMP_WAIT, FIN, ERR; all outputs registered.
REQ-005 In IDLE with start=1, the next state SHALL be LOAD; M, N, P SHALL be latched into M_o, N_o, P_o at that edge; done, err and err_code SHALL clear at that edge.
REQ-006 In LOAD, if any latched dimension is 0, the FSM SHALL go to ERR with err_code=01; otherwise it SHALL go to RSH_GO.
REQ-007 reshape_start SHALL be 1 for exactly the one cycle the FSM is in RSH_GO; the next state SHALL be RSH_WAIT.
REQ-008 Finish inputs SHALL be edge-detected against a registered copy: flags im_seen and wm_seen set on a 0->1 transition of the matching finish input.
- Flags SHALL clear in RSH_GO.
- A finish still high from a previous run SHALL NOT count until it has fallen and risen again.
REQ-009 RSH_WAIT SHALL go to CMP_GO in the cycle after both flags are set; completion order SHALL be irrelevant; simultaneous rises SHALL both be captured.
REQ-010 compute_start SHALL pulse for the one cycle in CMP_GO; CMP_GO SHALL go to CMP_WAIT.
REQ-011 CMP_WAIT SHALL go to FIN on a rising edge of compute_finish, using the REQ-008 edge rule.
REQ-012 FIN SHALL set done=1 and return to IDLE the next cycle; done SHALL hold until the next accepted start.
REQ-013 ERR SHALL set err=1 and return to IDLE the next cycle; err and err_code SHALL hold until the next accepted start.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 start SHALL be ignored outside IDLE; start held high SHALL launch a new run every time the FSM reaches IDLE.
REQ-016 Latency: start accepted at edge k gives reshape_start high in cycle k+2 (start -> LOAD -> RSH_GO).
REQ-017 M_o, N_o, P_o SHALL remain stable from LOAD until the next accepted start.

Reset
REQ-018 rst_n=0 SHALL immediately force the FSM to IDLE.
REQ-019 On reset, all outputs, flags and counters SHALL be 0, including a reset asserted mid-run.
REQ-020 After reset release, the first accepted start SHALL behave as a fresh run.

Configuration
REQ-021 Macro RESHAPE_SCHED_TIMEOUT_EN SHALL control the watchdog.
- Defined: a 32-bit counter clears on entry to RSH_WAIT and to CMP_WAIT and increments each cycle in those states. When it reaches TIMEOUT_CYCLES, the FSM goes to ERR with err_code=10.
- Undefined: no counter is built; the wait states wait indefinitely; err_code=10 never occurs.

Verification
REQ-022 Nominal run: M=4, N=8, P=5, start pulse; WM finish rises 10 cycles after reshape_start, IM finish after 20; compute_finish rises 30 cycles after compute_start. Required: compute_start exactly 1 cycle after the IM rise is sampled, done=1, busy=0, M_o/N_o/P_o = 4/8/5.
REQ-023 Stale finish: both reshaper finishes held high from a prior run and drop 1 cycle after reshape_start. Required: no early compute_start; it follows only the later 0->1 rise.
REQ-024 Zero dimension: P=0 with start. Required: no reshape_start, err=1, err_code=01, busy low 2 cycles after LOAD.
REQ-025 Timeout: with RESHAPE_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, WM finish never rises. Required: ERR after 16 cycles in RSH_WAIT, err_code=10, no compute_start.
REQ-026 Mid-run reset: rst_n pulled low during CMP_WAIT. Required: all outputs 0 immediately; a new start gives a complete nominal run.
REQ-027 Simultaneous finish: IM and WM finish rise in the same cycle. Required: CMP_GO entered the next cycle; compute_start high for exactly 1 cycle.
